// File: rtl/lcd_pkg.sv
// Shared LCD panel geometry and the line-fetch controller state encoding.
package lcd_pkg;

    localparam int unsigned LCD_H_ACTIVE        = 800;
    localparam int unsigned LCD_V_ACTIVE        = 480;
    localparam int unsigned LCD_BYTES_PER_PIXEL = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/lcd_fetch_addr_gen.sv
// Framebuffer line address: loads the frame base, then advances one line per accepted fetch.
// Latency: address valid the cycle after load/step.
// Backpressure: none; step only on an accepted request.
module lcd_fetch_addr_gen #(
    parameter int unsigned LINE_BYTES = 1600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] base,
    output logic [31:0] addr
);

    // Accumulates rather than multiplies; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= 32'd0;
        end else if (load) begin
            addr <= base;
        end else if (step) begin
            addr <= addr + 32'(LINE_BYTES);
        end
    end

endmodule

// File: rtl/lcd_line_fetch_ctrl.sv
// Double-buffered LCD line fetch controller; optional LCD_UNDERRUN_CNT_EN enables the underrun counter.
// Latency: first request 1 cycle after BEFORE_FRAME.
// Backpressure: REQ_VALID and payload held until REQ_READY.
module lcd_line_fetch_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned LINES      = LCD_V_ACTIVE,
    parameter int unsigned LINE_BYTES = LCD_H_ACTIVE * LCD_BYTES_PER_PIXEL
) (
    input  logic        CLK_PXCLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic [31:0] FB_BASE,
    input  logic        BEFORE_FRAME,
    input  logic        DE,
    output logic        REQ_VALID,
    input  logic        REQ_READY,
    output logic [31:0] REQ_ADDR,
    output logic [8:0]  REQ_LINE,
    output logic        REQ_BUF,
    input  logic        DONE,
    output logic        RD_BUF,
    output logic        UNDERRUN,
    output logic [15:0] UNDERRUN_CNT
);

    fetch_state_t state, state_nxt;
    logic [9:0]   next_line;
    logic         tgt_buf;
    logic         restart;
    logic         de_q;
    logic [1:0]   rdy, rdy_nxt;
    logic [1:0]   free_cnt;
    logic         bf, done_busy, accept, frame_start, pending, de_rise, de_fall;

    assign bf          = BEFORE_FRAME & ENABLE;
    assign done_busy   = (state == BUSY) & DONE;
    assign accept      = (state == ISSUE) & REQ_READY;
    // A start seen mid-fetch is deferred until that fetch's DONE.
    assign frame_start = ((state == IDLE) & bf) | (done_busy & (restart | bf));
    assign pending     = ENABLE & (free_cnt != 2'd0) & (next_line < 10'(LINES));
    assign de_rise     = DE & ~de_q;
    assign de_fall     = ~DE & de_q;

    assign REQ_VALID = (state == ISSUE);
    assign REQ_LINE  = next_line[8:0];
    assign REQ_BUF   = tgt_buf;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start || pending) state_nxt = ISSUE;
            ISSUE:   if (REQ_READY) state_nxt = BUSY;
            BUSY:    if (DONE) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Display release and fetch completion may land together; the fill wins on the same buffer.
    always_comb begin
        rdy_nxt = rdy;
        if (de_fall) rdy_nxt[RD_BUF] = 1'b0;
        if (done_busy && !restart) rdy_nxt[~tgt_buf] = 1'b1;
        if (frame_start) rdy_nxt = 2'b00;
    end

    always_ff @(posedge CLK_PXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            next_line <= 10'd0;
            tgt_buf   <= 1'b0;
            restart   <= 1'b0;
            de_q      <= 1'b0;
            rdy       <= 2'b00;
            free_cnt  <= 2'd0;
            RD_BUF    <= 1'b0;
            UNDERRUN  <= 1'b0;
        end else begin
            state    <= state_nxt;
            de_q     <= DE;
            rdy      <= rdy_nxt;
            UNDERRUN <= de_rise & ~rdy[RD_BUF];

            if (frame_start) begin
                next_line <= 10'd0;
                tgt_buf   <= 1'b0;
            end else if (accept) begin
                next_line <= next_line + 10'd1;
                tgt_buf   <= ~tgt_buf;
            end

            if (frame_start)                  restart <= 1'b0;
            else if (bf && (state != IDLE))   restart <= 1'b1;

            if (frame_start)  RD_BUF <= 1'b0;
            else if (de_fall) RD_BUF <= ~RD_BUF;

            if (frame_start) begin
                free_cnt <= 2'd2;
            end else if (accept && !de_fall) begin
                free_cnt <= free_cnt - 2'd1;
            end else if (de_fall && !accept && (free_cnt < 2'd2)) begin
                free_cnt <= free_cnt + 2'd1;
            end
        end
    end

`ifdef LCD_UNDERRUN_CNT_EN
    always_ff @(posedge CLK_PXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            UNDERRUN_CNT <= 16'd0;
        end else if (UNDERRUN && (UNDERRUN_CNT != 16'hFFFF)) begin
            UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
        end
    end
`else
    assign UNDERRUN_CNT = 16'd0;
`endif

    lcd_fetch_addr_gen #(
        .LINE_BYTES(LINE_BYTES)
    ) u_addr_gen (
        .clk  (CLK_PXCLK),
        .rst_n(RESET_N),
        .load (frame_start),
        .step (accept),
        .base (FB_BASE),
        .addr (REQ_ADDR)
    );

endmodule

// File: doc/lcd_line_fetch_ctrl.md
LCD_LINE_FETCH_CTRL -- requirements
Module: lcd_line_fetch_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 480, the number of active lines per frame.
REQ-002 SHALL have parameter LINE_BYTES, default 1600, the framebuffer bytes per line (800 px x 2 B).
REQ-003 SHALL have CLK_PXCLK, input, 1 bit: pixel clock, the only clock.
REQ-004 SHALL have RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ENABLE, input, 1 bit: permits new frames to start.
REQ-006 SHALL have FB_BASE, input, 32 bits: framebuffer byte base address, latched at frame start.
REQ-007 SHALL have BEFORE_FRAME and DE, inputs, 1 bit each, from the LCD timing generator.
REQ-008 SHALL have REQ_VALID (out, 1), REQ_READY (in, 1), REQ_ADDR (out, 32), REQ_LINE (out, 9) and REQ_BUF (out, 1): the line-fetch request channel.
REQ-009 SHALL have DONE, input, 1 bit: one-cycle pulse when the accepted fetch has fully landed in its line buffer.
REQ-010 SHALL have RD_BUF, output, 1 bit: the line-buffer index the display side reads.
REQ-011 SHALL have UNDERRUN (out, 1) and UNDERRUN_CNT (out, 16).

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, BUSY.
- IDLE->ISSUE when a fetch is pending.
- ISSUE->BUSY on REQ_VALID&&REQ_READY.
- BUSY->IDLE on DONE.
REQ-013 SHALL assert REQ_VALID only in ISSUE and hold REQ_VALID, REQ_ADDR, REQ_LINE and REQ_BUF stable until accepted; it never deasserts unaccepted.
REQ-014 SHALL, on BEFORE_FRAME with ENABLE=1, start a frame: latch FB_BASE, set next-fetch line to 0 and target buffer to 0, clear both buffer-ready flags, set RD_BUF=0, and mark two buffers free.
REQ-015 SHALL compute REQ_ADDR = FB_BASE + line*LINE_BYTES by accumulation (add LINE_BYTES per issued line, no multiplier), with 32-bit wrap-around.
REQ-016 SHALL issue a fetch whenever a buffer is free and the next-fetch line is less than LINES; the target buffer alternates 0,1,0,...
REQ-017 SHALL set the target buffer's ready flag on DONE.
REQ-018 SHALL, on the DE falling edge (end of a displayed line), clear the ready flag of RD_BUF, toggle RD_BUF, and free one buffer.
REQ-019 SHALL pulse UNDERRUN for one cycle on a DE rising edge whose RD_BUF ready flag is 0.
REQ-020 SHALL apply both effects in the same cycle when DONE and a DE falling edge coincide.
REQ-021 SHALL, when BEFORE_FRAME arrives in ISSUE or BUSY, record a restart and apply it after the in-flight DONE; the DONE completing the aborted fetch sets no ready flag.
REQ-022 SHALL ignore BEFORE_FRAME while ENABLE=0; an in-flight fetch completes and no further fetches issue.
REQ-023 SHALL issue no request for lines at or beyond LINES.
REQ-024 SHALL register DE internally for edge detection; first request latency is 1 cycle after BEFORE_FRAME.

Reset
REQ-025 SHALL, on RESET_N low, asynchronously clear the following to 0: REQ_VALID, REQ_ADDR, REQ_LINE, REQ_BUF, RD_BUF, UNDERRUN, UNDERRUN_CNT, the ready flags, the free count and the restart flag; the FSM returns to IDLE.
REQ-026 SHALL make reset mid-fetch drop REQ_VALID immediately; a later DONE in IDLE SHALL be ignored.

Configuration
REQ-027 SHALL, with LCD_UNDERRUN_CNT_EN defined, increment UNDERRUN_CNT on each UNDERRUN pulse, saturating at 16'hFFFF and cleared only by reset.
REQ-028 SHALL, without LCD_UNDERRUN_CNT_EN, tie UNDERRUN_CNT to 0; the UNDERRUN pulse is unaffected.

Structure
REQ-029 SHALL take LCD_H_ACTIVE=800, LCD_V_ACTIVE=480, LCD_BYTES_PER_PIXEL=2 and the fetch-state enum type from shared package lcd_pkg.
REQ-030 SHALL place the base-latch and accumulating address in one sub-module, lcd_fetch_addr_gen.

Verification
REQ-031 SHALL cover frame start: FB_BASE=0x1000_0000, BEFORE_FRAME, REQ_READY=1 -> requests line 0 at 0x1000_0000 buf 0, then line 1 at 0x1000_0640 buf 1 after the first DONE.
REQ-032 SHALL cover backpressure: REQ_READY=0 for 10 cycles -> REQ_VALID/REQ_ADDR stay constant, exactly one acceptance.
REQ-033 SHALL cover underrun: DONE withheld, DE rises for line 0 -> UNDERRUN 1-cycle pulse, UNDERRUN_CNT=1 (macro on) / 0 (macro off).
REQ-034 SHALL cover a full frame: 480 DE lines with prompt DONE -> 480 requests, last REQ_LINE=479, REQ_ADDR=FB_BASE+479*1600, no UNDERRUN.
REQ-035 SHALL cover restart: BEFORE_FRAME while BUSY -> no new request until DONE, then line 0 buf 0 with the new FB_BASE.
REQ-036 SHALL cover reset in ISSUE: RESET_N low -> REQ_VALID=0 same cycle, all outputs 0, stray DONE ignored.
